mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of the two requester ports and the memory port of mem_arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives
//            acks/read data to requesters and commands to memory)
//   master : environment view (requesters plus the data memory)
// Signal names keep the arbiter-side _i/_o direction suffixes.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    // requester 0 (instruction-cache miss path)
    logic              req0_i;
    logic              we0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [DATA_W-1:0] wdata0_i;
    logic              ack0_o;
    logic [DATA_W-1:0] rdata0_o;
    // requester 1 (data-cache miss / write-back path)
    logic              req1_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              ack1_o;
    logic [DATA_W-1:0] rdata1_o;
    // memory port
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;
    // watchdog
    logic              err_o;

    modport slave (
        input  req0_i, we0_i, addr0_i, wdata0_i,
        output ack0_o, rdata0_o,
        input  req1_i, we1_i, addr1_i, wdata1_i,
        output ack1_o, rdata1_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i,
        output err_o
    );

    modport master (
        output req0_i, we0_i, addr0_i, wdata0_i,
        input  ack0_o, rdata0_o,
        output req1_i, we1_i, addr1_i, wdata1_i,
        input  ack1_o, rdata1_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i,
        input  err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single off-chip data memory port between requester 0 (I-cache
// miss path) and requester 1 (D-cache miss / write-back path).
//
// Ports:
//   clk_i  - clock, everything on the rising edge
//   rst_i  - synchronous reset, active-high
//   bus    - mem_arbiter_if.slave: req/we/addr/wdata in and ack/rdata out per
//            requester, mem_enable/write/addr/data out, mem_ack/data in, err_o
//
// Flow: IDLE picks a winner (round-robin on a tie) and latches its command,
// BUSY holds the memory enable until mem_ack_i, RESP gives the winner a
// one-cycle ack with the read line that memory presents in that cycle.
//
// Optional build macro MEM_ARB_TIMEOUT_EN: adds a BUSY watchdog that forces
// completion after TIMEOUT cycles without mem_ack_i, returning rdata=0 and
// setting the sticky err_o. Without it err_o is tied low and BUSY waits for
// the memory indefinitely.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    if (TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_last;     // id of the last granted requester
    logic              r_gnt;      // id of the current winner
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_any;
    logic              w_win;
    logic              w_to;       // current transaction ended by the watchdog
    logic              w_timeout;  // watchdog fires this cycle
    logic              w_capture;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_mem_enable;
    logic              w_ack0;
    logic              w_ack1;
    logic              w_show0;
    logic              w_show1;

    assign w_any = bus.req0_i | bus.req1_i;
    // Single requester wins outright; on a tie the one not granted last wins.
    assign w_win = (bus.req0_i & bus.req1_i) ? ~r_last : bus.req1_i;

    // ---------------------------------------------------------------- watchdog
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_to;
    logic             r_err;

    // r_cnt holds the number of BUSY cycles already completed, so the
    // TIMEOUT-th BUSY cycle sees TIMEOUT-1.
    assign w_timeout = (r_state == BUSY) && !bus.mem_ack_i &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
                r_to  <= 1'b0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_to  <= 1'b1;
                r_err <= 1'b1;
            end
        end
    end

    assign w_to       = r_to;
    assign bus.err_o  = r_err;
`else
    assign w_timeout  = 1'b0;
    assign w_to       = 1'b0;
    assign bus.err_o  = 1'b0;
`endif

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // -------------------------------------------------------- next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = BUSY;
            BUSY:    if (bus.mem_ack_i || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ output logic
    always_comb begin
        w_mem_enable = 1'b0;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        w_show0      = 1'b0;
        w_show1      = 1'b0;
        case (r_state)
            BUSY: w_mem_enable = 1'b1;
            RESP: begin
                w_ack0  = ~r_gnt;
                w_ack1  = r_gnt;
                w_show0 = ~r_gnt & w_capture;
                w_show1 = r_gnt & w_capture;
            end
            default: ;
        endcase
    end

    // Memory drives the read line in the RESP cycle itself, so it is passed
    // straight through while acking and captured at the end of RESP to hold.
    assign w_capture   = ~r_we | w_to;
    assign w_resp_data = w_to ? '0 : bus.mem_data_i;

    // ----------------------------------------------------- latched command/data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt   <= w_win;
                r_last  <= w_win;
                r_we    <= w_win ? bus.we1_i    : bus.we0_i;
                r_addr  <= w_win ? bus.addr1_i  : bus.addr0_i;
                r_wdata <= w_win ? bus.wdata1_i : bus.wdata0_i;
            end
            if (w_show0) r_rdata0 <= w_resp_data;
            if (w_show1) r_rdata1 <= w_resp_data;
        end
    end

    assign bus.mem_enable_o = w_mem_enable;
    assign bus.mem_write_o  = r_we;
    assign bus.mem_addr_o   = r_addr;
    assign bus.mem_data_o   = r_wdata;
    assign bus.ack0_o       = w_ack0;
    assign bus.ack1_o       = w_ack1;
    assign bus.rdata0_o     = w_show0 ? w_resp_data : r_rdata0;
    assign bus.rdata1_o     = w_show1 ? w_resp_data : r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int TIMEOUT = 15;
    typedef logic [DATA_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------------------------------------------------- memory model
    int    mem_wait = 10;
    bit    spur     = 1'b0;
    int    mcnt     = 0;
    line_t rd_line  = '0;
    line_t mem_arr [addr_t];

    function automatic line_t dflt(addr_t a);
        return {8{a ^ 32'h5EED_0000}};
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Acks in the (mem_wait+1)-th enabled cycle, presents read data the
    // cycle after; data bus carries garbage at all other times.
    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
            bus.mem_ack_i = 1'b0;
            bus.mem_data_i = rand_line();
        end else if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
            mcnt = 0;
            bus.mem_data_i = rd_line;
        end else if (spur) begin
            spur = 1'b0;
            bus.mem_ack_i = 1'b1;
            rd_line = rand_line();
        end else begin
            bus.mem_data_i = rand_line();
            if (bus.mem_enable_o) begin
                mcnt++;
                if (mcnt == mem_wait + 1) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) mem_arr[bus.mem_addr_o] = bus.mem_data_o;
                    else rd_line = mem_arr.exists(bus.mem_addr_o) ?
                                   mem_arr[bus.mem_addr_o] : dflt(bus.mem_addr_o);
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // ------------------------------------------------------- reference model
    bit    pend [2];
    bit    p_we [2];
    addr_t p_addr [2];
    line_t p_data [2];
    int    last_g = 1;
    line_t last_rd [2];
    bit    rd_known [2];
    bit    exp_err = 1'b0;
    line_t ref_mem [addr_t];

    int    late_id = -1;
    int    late_k;
    bit    late_we;
    addr_t late_addr;
    line_t late_data;

    task automatic chk1(string tag, logic obs, logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(string tag, addr_t obs, addr_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkv(string tag, line_t obs, line_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(int id);
        return (id != 0) ? bus.ack1_o : bus.ack0_o;
    endfunction

    function automatic line_t rdata_of(int id);
        return (id != 0) ? bus.rdata1_o : bus.rdata0_o;
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drive_req(int id);
        if (id == 0) begin
            bus.req0_i = pend[0]; bus.we0_i = p_we[0];
            bus.addr0_i = p_addr[0]; bus.wdata0_i = p_data[0];
        end else begin
            bus.req1_i = pend[1]; bus.we1_i = p_we[1];
            bus.addr1_i = p_addr[1]; bus.wdata1_i = p_data[1];
        end
    endtask

    task automatic post(int id, bit we, addr_t a, line_t d);
        pend[id] = 1'b1; p_we[id] = we; p_addr[id] = a; p_data[id] = d;
        drive_req(id);
    endtask

    // Requester changes its command pins after being granted (req stays up).
    task automatic scramble(int id);
        if (id == 0) begin
            bus.we0_i = ~p_we[0]; bus.addr0_i = $urandom; bus.wdata0_i = rand_line();
        end else begin
            bus.we1_i = ~p_we[1]; bus.addr1_i = $urandom; bus.wdata1_i = rand_line();
        end
    endtask

    task automatic held(int id);
        if (rd_known[id]) chkv("rdata_hold", rdata_of(id), last_rd[id]);
    endtask

    task automatic model_reset();
        last_g = 1; exp_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; rd_known[i] = 1'b1; last_rd[i] = '0;
            drive_req(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    // One transaction, entered at a check point of an IDLE cycle with the
    // pending requests already on the pins; returns in the following IDLE.
    task automatic txn();
        int    w;
        int    n;
        bit    we;
        addr_t a;
        line_t d;
        line_t exp_rd;
        n = mem_wait;
        if (pend[0] && pend[1]) w = 1 - last_g;
        else if (pend[1])       w = 1;
        else                    w = 0;
        last_g = w; we = p_we[w]; a = p_addr[w]; d = p_data[w]; exp_rd = '0;
        if (we) ref_mem[a] = d;
        else    exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        for (int k = 1; k <= n + 2; k++) begin
            step();
            if (k <= n + 1) begin
                chk1("busy_en",    bus.mem_enable_o, 1'b1);
                chk1("busy_we",    bus.mem_write_o, we);
                chka("busy_addr",  bus.mem_addr_o, a);
                chkv("busy_wdata", bus.mem_data_o, d);
                chk1("busy_ack0",  bus.ack0_o, 1'b0);
                chk1("busy_ack1",  bus.ack1_o, 1'b0);
                held(0);
                held(1);
            end else begin
                chk1("resp_en",        bus.mem_enable_o, 1'b0);
                chk1("resp_ack_win",   ack_of(w), 1'b1);
                chk1("resp_ack_other", ack_of(1 - w), 1'b0);
                if (!we) begin
                    chkv("resp_rdata", rdata_of(w), exp_rd);
                    last_rd[w] = exp_rd; rd_known[w] = 1'b1;
                end else begin
                    rd_known[w] = 1'b0;
                end
                held(1 - w);
                pend[w] = 1'b0;
                drive_req(w);
            end
            if (k == 1) scramble(w);
            if (late_id >= 0 && k == late_k) begin
                post(late_id, late_we, late_addr, late_data);
                late_id = -1;
            end
        end
        step();
        chk1("idle_en",   bus.mem_enable_o, 1'b0);
        chk1("idle_ack0", bus.ack0_o, 1'b0);
        chk1("idle_ack1", bus.ack1_o, 1'b0);
        chk1("idle_err",  bus.err_o, exp_err);
        held(0);
        held(1);
    endtask

    function automatic addr_t rand_addr();
        return addr_t'($urandom_range(0, 7)) << 5;
    endfunction

    // ------------------------------------------------------------- stimulus
    initial begin
        bus.mem_ack_i = 1'b0;
        bus.mem_data_i = '0;
        model_reset();
        mem_arr[32'h40] = {32{8'hA5}};
        ref_mem[32'h40] = {32{8'hA5}};

        // reset state
        step(); step();
        chk1("rst_en",    bus.mem_enable_o, 1'b0);
        chk1("rst_we",    bus.mem_write_o, 1'b0);
        chka("rst_addr",  bus.mem_addr_o, '0);
        chkv("rst_wdata", bus.mem_data_o, '0);
        chk1("rst_ack0",  bus.ack0_o, 1'b0);
        chk1("rst_ack1",  bus.ack1_o, 1'b0);
        chkv("rst_rd0",   bus.rdata0_o, '0);
        chkv("rst_rd1",   bus.rdata1_o, '0);
        chk1("rst_err",   bus.err_o, 1'b0);
        rst = 1'b0;
        step();

        // single read with a 10-cycle memory wait: ack 12 cycles after req edge
        mem_wait = 10;
        post(0, 1'b0, 32'h40, rand_line());
        txn();

        // single write by requester 1, then read it back through requester 0
        post(1, 1'b1, 32'h80, line_t'(32'h1234));
        txn();
        post(0, 1'b0, 32'h80, rand_line());
        txn();

        // both requesting continuously from reset: grants 0,1,0,1
        do_reset();
        mem_wait = 3;
        post(0, 1'b0, 32'h40, rand_line());
        post(1, 1'b1, 32'hA0, rand_line());
        for (int i = 0; i < 4; i++) begin
            txn();
            if (!pend[0]) post(0, 1'b0, rand_addr(), rand_line());
            if (!pend[1]) post(1, 1'b1, rand_addr(), rand_line());
        end
        while (pend[0] || pend[1]) txn();

        // requester 1 arrives mid-BUSY of requester 0: no preemption
        mem_wait = 6;
        post(0, 1'b0, 32'hC0, rand_line());
        late_id = 1; late_k = 4; late_we = 1'b0; late_addr = 32'h100; late_data = rand_line();
        txn();
        txn();

        // reset three cycles into BUSY
        mem_wait = 10;
        post(0, 1'b1, 32'h60, rand_line());
        for (int k = 1; k <= 3; k++) begin
            step();
            chk1("prerst_en", bus.mem_enable_o, 1'b1);
        end
        rst = 1'b1;
        model_reset();
        step();
        chk1("midrst_en",   bus.mem_enable_o, 1'b0);
        chk1("midrst_ack0", bus.ack0_o, 1'b0);
        chk1("midrst_ack1", bus.ack1_o, 1'b0);
        rst = 1'b0;
        step();
        chk1("postrst_en",   bus.mem_enable_o, 1'b0);
        chk1("postrst_ack0", bus.ack0_o, 1'b0);
        post(0, 1'b0, 32'h40, rand_line());
        txn();
        post(0, 1'b0, 32'h60, rand_line());
        txn();

        // memory ack while idle is ignored
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("spur_en",   bus.mem_enable_o, 1'b0);
            chk1("spur_ack0", bus.ack0_o, 1'b0);
            chk1("spur_ack1", bus.ack1_o, 1'b0);
        end

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            for (int id = 0; id < 2; id++)
                if (!pend[id] && $urandom_range(0, 1) == 1)
                    post(id, 1'($urandom_range(0, 1)), rand_addr(), rand_line());
            if (!pend[0] && !pend[1])
                post($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), rand_line());
            mem_wait = $urandom_range(0, 6);
            if (pend[0] != pend[1] && $urandom_range(0, 1) == 1) begin
                late_id = pend[0] ? 1 : 0;
                late_k = $urandom_range(1, mem_wait + 2);
                late_we = 1'($urandom_range(0, 1));
                late_addr = rand_addr();
                late_data = rand_line();
            end
            txn();
        end
        while (pend[0] || pend[1]) txn();

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never acks: watchdog completes after TIMEOUT BUSY cycles
        do_reset();
        mem_wait = 1000;
        post(0, 1'b0, 32'h40, rand_line());
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step();
            if (k <= TIMEOUT) begin
                chk1("to_en",   bus.mem_enable_o, 1'b1);
                chk1("to_err0", bus.err_o, 1'b0);
                chk1("to_ack0", bus.ack0_o, 1'b0);
            end else begin
                chk1("to_resp_en",  bus.mem_enable_o, 1'b0);
                chk1("to_resp_ack", bus.ack0_o, 1'b1);
                chkv("to_rdata",    bus.rdata0_o, '0);
                chk1("to_err",      bus.err_o, 1'b1);
                pend[0] = 1'b0;
                drive_req(0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("to_err_sticky", bus.err_o, 1'b1);
            chk1("to_idle_en",    bus.mem_enable_o, 1'b0);
        end
        do_reset();
        step();
        chk1("to_err_clr", bus.err_o, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
